// File: rtl/seq_pkg.sv
// Shared types and constants for the memory-game sequence display and verifier stages.
package seq_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 5;
  localparam int SEQ_W      = 20;
  localparam int LVL_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requested levels above the number of stored digits show every digit once.
  function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
    if (lvl > LVL_W'(MAX_DIGITS))
      return LVL_W'(MAX_DIGITS);
    return lvl;
  endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Loadable down-counter that measures how long a digit or gap stays on screen.
module seq_dwell_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - CNT_W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_display.sv
// Shows the first LVL digits of a latched sequence, each followed by a blank gap,
// then pulses display_done to hand over to the verifier.
module seq_display
  import seq_pkg::*;
#(
  parameter int SHOW_CYCLES  = 50_000_000,
  parameter int BLANK_CYCLES = 12_500_000,
  parameter int CNT_W        = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               newSequence,
  input  logic [LVL_W-1:0]   LVL,
  input  logic [SEQ_W-1:0]   Sequence,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_valid,
  output logic               busy,
  output logic               display_done
);

  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);

  state_t               state_q, state_d;
  logic [SEQ_W-1:0]     seq_q;
  logic [LVL_W-1:0]     eff_lvl_q;
  logic [LVL_W-1:0]     idx_q;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_zero;
  logic                 accept;
  logic                 advance;

  logic [DIGIT_W-1:0]   digit_p1;
  logic                 vld_p1;
  logic                 done_p1;

  seq_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // Stage p0: sequencing FSM. The display_done cycle still counts as busy,
  // so a request is only taken once that pulse has cleared.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = SHOW_LD;
    accept   = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (newSequence && !done_p1) begin
          accept = 1'b1;
          if (clamp_lvl(LVL) != '0) begin
            state_d  = SHOW;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHOW: begin
        if (tmr_zero) begin
          state_d  = BLANK;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LD;
        end
      end
      BLANK: begin
        if (tmr_zero) begin
          advance = 1'b1;
          if ((idx_q + LVL_W'(1)) < eff_lvl_q) begin
            state_d  = SHOW;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and digit index; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        idx_q <= '0;
      else if (advance)
        idx_q <= idx_q + LVL_W'(1);
    end
  end

  // Latched sequence and level; the head nibble is always the digit on show.
  always_ff @(posedge clk) begin
    if (accept) begin
      seq_q     <= Sequence;
      eff_lvl_q <= clamp_lvl(LVL);
    end else if (advance) begin
      seq_q <= {seq_q[SEQ_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
    end
  end

  // Stage p1: outputs registered from the state so nothing leaks through
  // combinationally from the inputs; they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_p1 <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      vld_p1   <= (state_q == SHOW);
      digit_p1 <= (state_q == SHOW) ? seq_q[SEQ_W-1 -: DIGIT_W] : '0;
      done_p1  <= (state_q == DONE);
    end
  end

  assign digit_out    = digit_p1;
  assign digit_valid  = vld_p1;
  assign display_done = done_p1;
  assign busy         = (state_q != IDLE) || done_p1;

endmodule

// File: tb/tb_seq_display.sv
// Bench for seq_display with short dwell times (show 3, blank 2).
module tb_seq_display;

  localparam int S = 3;
  localparam int B = 2;
  localparam int P = S + B;
  localparam int LOGN = 1024;

  logic        clk;
  logic        rst;
  logic        newSequence;
  logic [2:0]  LVL;
  logic [19:0] Sequence;
  logic [3:0]  digit_out;
  logic        digit_valid;
  logic        busy;
  logic        display_done;

  seq_display #(
    .SHOW_CYCLES (S),
    .BLANK_CYCLES(B),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .newSequence (newSequence),
    .LVL         (LVL),
    .Sequence    (Sequence),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .busy        (busy),
    .display_done(display_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Output log, indexed by the edge after which the value was seen.
  logic [3:0] dig_log  [LOGN];
  logic       vld_log  [LOGN];
  logic       done_log [LOGN];
  logic       busy_log [LOGN];

  // Reference model: a run is described only by its acceptance edge, sequence
  // and effective level; outputs follow from the display timetable.
  int          ecount = 0;
  bit          m_active = 0;
  int          m_t0 = 0;
  logic [19:0] m_seq = '0;
  int          m_eff = 0;
  logic [3:0]  e_digit = '0;
  logic        e_valid = 0;
  logic        e_done = 0;
  logic        e_busy = 0;
  logic        prev_busy;
  int          k, endk, di;
  logic [19:0] shifted;

  always @(posedge clk) begin
    prev_busy = e_busy;
    if (rst) begin
      m_active = 0;
    end else if (newSequence && !prev_busy) begin
      m_active = 1;
      m_t0     = ecount;
      m_seq    = Sequence;
      m_eff    = (LVL > 3'd5) ? 5 : int'(LVL);
    end
    e_digit = '0; e_valid = 0; e_done = 0; e_busy = 0;
    if (m_active) begin
      k    = ecount - m_t0;
      endk = 1 + m_eff * P;
      if (k > endk) begin
        m_active = 0;
      end else begin
        e_busy = 1;
        e_done = (k == endk);
        if (k >= 1 && ((k - 1) / P) < m_eff && ((k - 1) % P) < S) begin
          di      = (k - 1) / P;
          shifted = m_seq >> (4 * (4 - di));
          e_digit = shifted[3:0];
          e_valid = 1;
        end
      end
    end
    #1;
    if (ecount < LOGN) begin
      dig_log[ecount]  = digit_out;
      vld_log[ecount]  = digit_valid;
      done_log[ecount] = display_done;
      busy_log[ecount] = busy;
    end
    check("digit_out",    32'(digit_out),    32'(e_digit));
    check("digit_valid",  32'(digit_valid),  32'(e_valid));
    check("display_done", 32'(display_done), 32'(e_done));
    check("busy",         32'(busy),         32'(e_busy));
    ecount++;
  end

  task automatic wait_until(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  task automatic pulse(input logic [19:0] sq, input logic [2:0] lv, output int base);
    newSequence = 1'b1;
    Sequence    = sq;
    LVL         = lv;
    @(negedge clk);
    newSequence = 1'b0;
    base        = ecount - 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  int b0, b1, b2, b3, b4, rises, dones;

  initial begin
    rst         = 1'b1;
    newSequence = 1'b1;
    LVL         = 3'd3;
    Sequence    = 20'h12345;
    repeat (2) @(negedge clk);
    check("rst_digit", 32'(digit_out),    32'h0);
    check("rst_valid", 32'(digit_valid),  32'h0);
    check("rst_busy",  32'(busy),         32'h0);
    check("rst_done",  32'(display_done), 32'h0);

    // Release reset with the request still high: accepted at the next edge.
    rst = 1'b0;
    pulse(20'h12345, 3'd3, b0);
    Sequence = 20'h00000;
    wait_until(b0 + 5);
    newSequence = 1'b1; Sequence = 20'hFFFFF; LVL = 3'd1;
    @(negedge clk);
    newSequence = 1'b0; Sequence = 20'h00000;

    // Request held across the display_done cycle (ignored) into the next (taken).
    wait_until(b0 + 17);
    newSequence = 1'b1; Sequence = 20'h5A000; LVL = 3'd2;
    @(negedge clk);
    @(negedge clk);
    newSequence = 1'b0;
    b1 = b0 + 18;

    check("r1_d0_first", 32'(dig_log[b0 + 1]),  32'h1);
    check("r1_d0_last",  32'(dig_log[b0 + 3]),  32'h1);
    check("r1_gap0",     32'(vld_log[b0 + 4]),  32'h0);
    check("r1_d1",       32'(dig_log[b0 + 6]),  32'h2);
    check("r1_d1_last",  32'(dig_log[b0 + 8]),  32'h2);
    check("r1_d2",       32'(dig_log[b0 + 11]), 32'h3);
    check("r1_gap2",     32'(vld_log[b0 + 15]), 32'h0);
    check("r1_done_pre", 32'(done_log[b0 + 15]), 32'h0);
    check("r1_done",     32'(done_log[b0 + 16]), 32'h1);
    check("r1_busy_0",   32'(busy_log[b0]),      32'h1);
    check("r1_busy_16",  32'(busy_log[b0 + 16]), 32'h1);
    check("r1_busy_17",  32'(busy_log[b0 + 17]), 32'h0);
    rises = 0;
    for (int e = b0; e <= b0 + 17; e++)
      if (vld_log[e] && !vld_log[e - 1]) rises++;
    check("r1_rises", 32'(rises), 32'd3);

    wait_idle();
    check("r2_d0",   32'(dig_log[b1 + 1]),   32'h5);
    check("r2_d1",   32'(dig_log[b1 + 6]),   32'hA);
    check("r2_done", 32'(done_log[b1 + 11]), 32'h1);

    pulse(20'hA9876, 3'd7, b2);
    wait_idle();
    check("r3_d0",       32'(dig_log[b2 + 1]),   32'hA);
    check("r3_d1",       32'(dig_log[b2 + 6]),   32'h9);
    check("r3_d2",       32'(dig_log[b2 + 11]),  32'h8);
    check("r3_d3",       32'(dig_log[b2 + 16]),  32'h7);
    check("r3_d4",       32'(dig_log[b2 + 21]),  32'h6);
    check("r3_gap4",     32'(vld_log[b2 + 24]),  32'h0);
    check("r3_done_pre", 32'(done_log[b2 + 25]), 32'h0);
    check("r3_done",     32'(done_log[b2 + 26]), 32'h1);

    pulse(20'h12345, 3'd0, b3);
    wait_idle();
    check("r4_done_0", 32'(done_log[b3]),     32'h0);
    check("r4_done_1", 32'(done_log[b3 + 1]), 32'h1);
    check("r4_busy_0", 32'(busy_log[b3]),     32'h1);
    check("r4_busy_1", 32'(busy_log[b3 + 1]), 32'h1);
    check("r4_busy_2", 32'(busy_log[b3 + 2]), 32'h0);
    check("r4_valid",  32'(vld_log[b3 + 1]),  32'h0);

    // Abort mid-SHOW.
    pulse(20'h12345, 3'd3, b4);
    @(negedge clk);
    check("r5_showing", 32'(digit_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("r5_rst_digit", 32'(digit_out),    32'h0);
    check("r5_rst_valid", 32'(digit_valid),  32'h0);
    check("r5_rst_busy",  32'(busy),         32'h0);
    check("r5_rst_done",  32'(display_done), 32'h0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    dones = 0;
    for (int e = b4; e < ecount; e++)
      if (done_log[e]) dones++;
    check("r5_no_done", 32'(dones), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
